mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (imem) and the MEM-stage data requester (dmem) of the 5-stage pipeline.
- Buffers one request per requester and issues at most one memory transaction at a time.
- Routes each mem_resp and its rdata back to the requester that owns the transaction.
- Sits between the IF/MEM stages and the cache/memory model; the pipeline's stage-advance logic treats imem_resp and dmem_resp exactly as if each side had a private port.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active low (0 = reset)
imem_addr  in  ADDR_W  fetch address, valid while imem_rmask != 0
imem_rmask  in  4  fetch byte mask; nonzero for one cycle = request pulse
imem_rdata  out  DATA_W  fetch data, valid when imem_resp=1
imem_resp  out  1  one-cycle fetch completion
dmem_addr  in  ADDR_W  data address
dmem_rmask  in  4  load byte mask; nonzero = load request pulse
dmem_wmask  in  4  store byte mask; nonzero = store request pulse
dmem_wdata  in  DATA_W  store data
dmem_rdata  out  DATA_W  load data, valid when dmem_resp=1
dmem_resp  out  1  one-cycle load/store completion
mem_addr  out  ADDR_W  memory address
mem_rmask  out  4  memory read mask; one-cycle pulse per transaction
mem_wmask  out  4  memory write mask; one-cycle pulse per transaction
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_resp  in  1  one-cycle completion from memory, any latency >= 1 cycle after issue

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE; both pending buffers are cleared; last_grant=IMEM, so dmem wins the first tie.
  - All outputs are 0: masks, resps, addr, wdata, rdata.
- States:
  - IDLE: no transaction outstanding.
  - BUSY_I: imem transaction outstanding.
  - BUSY_D: dmem transaction outstanding.
- Request capture:
  - A request is captured into its side's pending buffer (addr, masks, wdata) in the cycle its mask is nonzero, unless it is issued to memory that same cycle.
  - A request with both dmem_rmask and dmem_wmask nonzero is illegal; the bench flags it with an assertion and the RTL treats it as a store.
- Issue happens only in IDLE. Candidates are the pending buffers plus any fresh request present this cycle.
  - Exactly one candidate: drive it on mem_* this cycle (zero added latency for a fresh request). Go to BUSY_I or BUSY_D.
  - Both candidates: grant the side other than last_grant (round robin). The loser stays pending. Update last_grant.
  - mem_rmask/mem_wmask are nonzero for exactly the issue cycle. mem_addr and mem_wdata are don't-care outside it but are held stable in the RTL.
- Completion, when mem_resp=1 in BUSY_X:
  - Assert X_resp=1 and X_rdata=mem_rdata combinationally in the same cycle.
  - Go to IDLE at the next edge.
  - The other side's resp stays 0 and its rdata stays at its last value.
  - No issue happens in the mem_resp cycle; the earliest next issue is the following cycle.
- Store responses: dmem_resp pulses and dmem_rdata carries mem_rdata unchanged; the pipeline ignores it.
- Boundary conditions:
  - A request arriving in the same cycle as mem_resp is captured as pending and issued the next cycle.
  - A second request from a side whose request is already pending or outstanding is a protocol violation: assertion fires, and the RTL ignores the request (the buffer is not overwritten).
  - mem_resp in IDLE (stray, or after a mid-transaction reset) is dropped; no requester resp pulses.
  - Reset mid-transaction discards the outstanding transaction and both pending buffers. Memory is assumed reset with the arbiter.
  - A pending request waits at most one foreign transaction (round-robin guarantee).
- Latency: with the port idle, requester pulse to X_resp equals the memory latency. Each lost arbitration adds the foreign transaction's latency plus 1 cycle.

Decomposition:
- Shared package (rv32i_types): mem_req_t struct {addr, rmask, wmask, wdata}; arb_state_t enum {IDLE, BUSY_I, BUSY_D}; requester_t enum {REQ_IMEM, REQ_DMEM}.
- One sub-module: mem_req_buf, a single-entry request holding register with capture/clear and a valid flag, instantiated once per requester.
- The FSM, grant and response routing stay in mem_port_arbiter.

Test Plan:
1. Reset to idle: hold rst=0 for 2 cycles, then rst=1 -> all mem_* masks 0, imem_resp=dmem_resp=0, state IDLE.
2. Lone fetch: imem pulse addr=0x1eceb000, rmask=0xF; memory responds 3 cycles later with rdata=0x00000013 -> mem_rmask=0xF in the pulse cycle; imem_resp=1 with imem_rdata=0x00000013 exactly 3 cycles later; dmem_resp stays 0.
3. Simultaneous requests: imem 0x1eceb004 and dmem load 0x1eceb100 (rmask=0xF) in the same cycle after reset -> dmem issued first; imem issued the cycle after dmem_resp; each resp carries its own rdata.
4. Store then back-to-back fetches: dmem store wmask=0x3 wdata=0xdeadbeef at 0x1eceb200 while imem is outstanding -> store pending until imem_resp, issued next cycle with mem_wmask=0x3 and mem_wdata=0xdeadbeef; the next imem pulse waits for the store (round robin alternates).
5. Request in response cycle: new imem pulse in the same cycle mem_resp completes the prior fetch -> previous imem_resp=1 that cycle; new mem_rmask issued the following cycle.
6. Reset mid-transaction: rst=0 while in BUSY_D with imem pending, then mem_resp=1 arrives after rst=1 -> no resp pulses, state IDLE, pending imem discarded.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: request record, FSM states
// and requester identities.
package rv32i_types;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0] addr;
      logic [3:0]            rmask;
      logic [3:0]            wmask;
      logic [MEM_DATA_W-1:0] wdata;
   } mem_req_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_IMEM = 1'b0,
      REQ_DMEM = 1'b1
   } requester_t;

   // Round robin: on a tie the side that was not granted last wins.
   function automatic requester_t rr_pick(input requester_t last);
      return (last == REQ_IMEM) ? REQ_DMEM : REQ_IMEM;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_req_buf.sv
// Single-entry request holding register: captures a request that could not be
// issued immediately and releases it when the arbiter issues it.
module mem_req_buf
   import rv32i_types::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              capture,
   input  logic              clear,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [3:0]        rmask_in,
   input  logic [3:0]        wmask_in,
   input  logic [DATA_W-1:0] wdata_in,
   output logic              valid,
   output logic [ADDR_W-1:0] addr,
   output logic [3:0]        rmask,
   output logic [3:0]        wmask,
   output logic [DATA_W-1:0] wdata
);

   mem_req_t entry;

   // Capture wins over clear; the arbiter never asserts both for one side.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= 1'b0;
         entry <= '0;
      end else if (capture) begin
         valid       <= 1'b1;
         entry.addr  <= addr_in;
         entry.rmask <= rmask_in;
         entry.wmask <= wmask_in;
         entry.wdata <= wdata_in;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

   assign addr  = entry.addr;
   assign rmask = entry.rmask;
   assign wmask = entry.wmask;
   assign wdata = entry.wdata;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM-stage data port.
// One transaction at a time, one pending request per side, round-robin on ties.
module mem_port_arbiter
   import rv32i_types::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] imem_addr,
   input  logic [3:0]        imem_rmask,
   output logic [DATA_W-1:0] imem_rdata,
   output logic              imem_resp,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [3:0]        dmem_rmask,
   input  logic [3:0]        dmem_wmask,
   input  logic [DATA_W-1:0] dmem_wdata,
   output logic [DATA_W-1:0] dmem_rdata,
   output logic              dmem_resp,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_rmask,
   output logic [3:0]        mem_wmask,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_resp,
   output logic [1:0]        dbg_state
);

   // Handshake: a nonzero request mask is a one-cycle request pulse; X_resp is a
   // one-cycle completion with X_rdata valid in that cycle; memory accepts any
   // issue pulse and returns exactly one mem_resp at least one cycle later.

   arb_state_t state, state_n;
   requester_t last_grant, last_grant_n;

   logic i_fresh, d_fresh, i_accept, d_accept;
   logic i_pend_v, d_pend_v, i_cand, d_cand;
   logic issue_i, issue_d, comp_i, comp_d;
   logic i_capture, d_capture;
   logic d_is_store;

   logic [ADDR_W-1:0] i_pend_addr, d_pend_addr;
   logic [3:0]        i_pend_rmask, i_pend_wmask, d_pend_rmask, d_pend_wmask;
   logic [DATA_W-1:0] i_pend_wdata, d_pend_wdata;

   mem_req_t i_fresh_req, d_fresh_req, i_cand_req, d_cand_req, issue_req;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, ird_q, drd_q;

   // A side may present a new request unless one is already pending, or one is
   // outstanding and not completing this cycle; such requests are dropped.
   always_comb begin
      i_fresh    = |imem_rmask;
      d_is_store = |dmem_wmask;
      d_fresh    = (|dmem_rmask) | d_is_store;
      i_accept   = rst && i_fresh && !i_pend_v && !(state == BUSY_I && !mem_resp);
      d_accept   = rst && d_fresh && !d_pend_v && !(state == BUSY_D && !mem_resp);

      i_fresh_req.addr  = imem_addr;
      i_fresh_req.rmask = imem_rmask;
      i_fresh_req.wmask = 4'h0;
      i_fresh_req.wdata = '0;

      // A request with both masks set is treated as a store.
      d_fresh_req.addr  = dmem_addr;
      d_fresh_req.rmask = d_is_store ? 4'h0 : dmem_rmask;
      d_fresh_req.wmask = dmem_wmask;
      d_fresh_req.wdata = dmem_wdata;

      i_cand_req.addr  = i_pend_addr;
      i_cand_req.rmask = i_pend_rmask;
      i_cand_req.wmask = i_pend_wmask;
      i_cand_req.wdata = i_pend_wdata;
      if (!i_pend_v) i_cand_req = i_fresh_req;

      d_cand_req.addr  = d_pend_addr;
      d_cand_req.rmask = d_pend_rmask;
      d_cand_req.wmask = d_pend_wmask;
      d_cand_req.wdata = d_pend_wdata;
      if (!d_pend_v) d_cand_req = d_fresh_req;

      i_cand = i_pend_v | i_accept;
      d_cand = d_pend_v | d_accept;
   end

   always_comb begin
      state_n      = state;
      last_grant_n = last_grant;
      issue_i      = 1'b0;
      issue_d      = 1'b0;
      comp_i       = 1'b0;
      comp_d       = 1'b0;
      case (state)
         IDLE: begin
            if (rst) begin
               if (i_cand && d_cand) begin
                  if (rr_pick(last_grant) == REQ_DMEM) issue_d = 1'b1;
                  else                                 issue_i = 1'b1;
               end else if (d_cand) begin
                  issue_d = 1'b1;
               end else if (i_cand) begin
                  issue_i = 1'b1;
               end
            end
            if (issue_d) begin
               state_n      = BUSY_D;
               last_grant_n = REQ_DMEM;
            end else if (issue_i) begin
               state_n      = BUSY_I;
               last_grant_n = REQ_IMEM;
            end
         end
         BUSY_I: begin
            if (mem_resp) begin
               comp_i  = 1'b1;
               state_n = IDLE;
            end
         end
         BUSY_D: begin
            if (mem_resp) begin
               comp_d  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign i_capture = i_accept && !issue_i;
   assign d_capture = d_accept && !issue_d;

   mem_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ibuf (
      .clk      (clk),
      .rst      (rst),
      .capture  (i_capture),
      .clear    (issue_i),
      .addr_in  (i_fresh_req.addr),
      .rmask_in (i_fresh_req.rmask),
      .wmask_in (i_fresh_req.wmask),
      .wdata_in (i_fresh_req.wdata),
      .valid    (i_pend_v),
      .addr     (i_pend_addr),
      .rmask    (i_pend_rmask),
      .wmask    (i_pend_wmask),
      .wdata    (i_pend_wdata)
   );

   mem_req_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dbuf (
      .clk      (clk),
      .rst      (rst),
      .capture  (d_capture),
      .clear    (issue_d),
      .addr_in  (d_fresh_req.addr),
      .rmask_in (d_fresh_req.rmask),
      .wmask_in (d_fresh_req.wmask),
      .wdata_in (d_fresh_req.wdata),
      .valid    (d_pend_v),
      .addr     (d_pend_addr),
      .rmask    (d_pend_rmask),
      .wmask    (d_pend_wmask),
      .wdata    (d_pend_wdata)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         last_grant <= REQ_IMEM;
         addr_q     <= '0;
         wdata_q    <= '0;
         ird_q      <= '0;
         drd_q      <= '0;
      end else begin
         state      <= state_n;
         last_grant <= last_grant_n;
         if (issue_i || issue_d) begin
            addr_q  <= issue_req.addr;
            wdata_q <= issue_req.wdata;
         end
         if (comp_i) ird_q <= mem_rdata;
         if (comp_d) drd_q <= mem_rdata;
      end
   end

   // Issue goes out combinationally so a fresh request sees no added latency;
   // address and write data hold their last issued value between transactions.
   always_comb begin
      issue_req = issue_d ? d_cand_req : i_cand_req;
      mem_rmask = 4'h0;
      mem_wmask = 4'h0;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if (issue_i || issue_d) begin
         mem_rmask = issue_req.rmask;
         mem_wmask = issue_req.wmask;
         mem_addr  = issue_req.addr;
         mem_wdata = issue_req.wdata;
      end
   end

   assign imem_resp  = comp_i;
   assign dmem_resp  = comp_d;
   assign imem_rdata = comp_i ? mem_rdata : ird_q;
   assign dmem_rdata = comp_d ? mem_rdata : drd_q;
   assign dbg_state  = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// random traffic against a queue-based model of the shared port.
module tb_mem_port_arbiter;
   import rv32i_types::*;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_rmask;
   logic [3:0]  dmem_wmask;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic [31:0] mem_addr;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;
   logic [1:0]  dbg_state;

   mem_port_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_rmask (imem_rmask),
      .imem_rdata (imem_rdata),
      .imem_resp  (imem_resp),
      .dmem_addr  (dmem_addr),
      .dmem_rmask (dmem_rmask),
      .dmem_wmask (dmem_wmask),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_resp  (dmem_resp),
      .mem_addr   (mem_addr),
      .mem_rmask  (mem_rmask),
      .mem_wmask  (mem_wmask),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_resp   (mem_resp),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_next;
   int   n_tests;
   int   n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Port-level view: each side owns a queue of waiting requests, the memory
   // is owned by nobody (0), imem (1) or dmem (2); ties go to the side not
   // served last.
   mem_req_t    qi[$];
   mem_req_t    qd[$];
   int          owner;
   int          last_side;
   int          side;
   mem_req_t    r;
   logic [31:0] m_ird, m_drd;
   logic [3:0]  e_rm, e_wm;
   logic        e_ir, e_dr;
   arb_state_t  e_state;

   always @(negedge clk) begin
      if (!rst) begin
         qi.delete();
         qd.delete();
         owner     = 0;
         last_side = 1;
         m_ird     = '0;
         m_drd     = '0;
      end else begin
         assert (!((|dmem_rmask) && (|dmem_wmask)))
            else $error("illegal dmem request with both masks set");
         assert (!(|imem_rmask) || (qi.size() == 0 && (owner != 1 || mem_resp)))
            else $error("imem request while one is in flight");
         assert (!((|dmem_rmask) || (|dmem_wmask)) || (qd.size() == 0 && (owner != 2 || mem_resp)))
            else $error("dmem request while one is in flight");

         e_state = (owner == 1) ? BUSY_I : (owner == 2) ? BUSY_D : IDLE;
         check("state", 32'(dbg_state), 32'(e_state));

         e_ir = (owner == 1) && mem_resp;
         e_dr = (owner == 2) && mem_resp;
         if (e_ir) m_ird = mem_rdata;
         if (e_dr) m_drd = mem_rdata;

         if (|imem_rmask) begin
            r.addr  = imem_addr;
            r.rmask = imem_rmask;
            r.wmask = 4'h0;
            r.wdata = '0;
            qi.push_back(r);
         end
         if ((|dmem_rmask) || (|dmem_wmask)) begin
            r.addr  = dmem_addr;
            r.rmask = (|dmem_wmask) ? 4'h0 : dmem_rmask;
            r.wmask = dmem_wmask;
            r.wdata = dmem_wdata;
            qd.push_back(r);
         end

         side = 0;
         if (owner == 0) begin
            if (qi.size() > 0 && qd.size() > 0) side = (last_side == 1) ? 2 : 1;
            else if (qd.size() > 0)             side = 2;
            else if (qi.size() > 0)             side = 1;
         end
         e_rm = 4'h0;
         e_wm = 4'h0;
         if (side == 1) r = qi.pop_front();
         if (side == 2) r = qd.pop_front();
         if (side != 0) begin
            e_rm      = r.rmask;
            e_wm      = r.wmask;
            owner     = side;
            last_side = side;
         end

         check("mem_rmask", 32'(mem_rmask), 32'(e_rm));
         check("mem_wmask", 32'(mem_wmask), 32'(e_wm));
         if (side != 0) check("mem_addr", mem_addr, r.addr);
         if (|e_wm)     check("mem_wdata", mem_wdata, r.wdata);
         check("imem_resp", 32'(imem_resp), 32'(e_ir));
         check("dmem_resp", 32'(dmem_resp), 32'(e_dr));
         check("imem_rdata", imem_rdata, m_ird);
         check("dmem_rdata", dmem_rdata, m_drd);

         if (e_ir || e_dr) owner = 0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply(input logic [3:0] irm, input logic [31:0] ia,
                        input logic [3:0] drm, input logic [3:0] dwm,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input logic mr, input logic [31:0] mrd);
      rst        = rst_next;
      imem_rmask = irm;
      imem_addr  = ia;
      dmem_rmask = drm;
      dmem_wmask = dwm;
      dmem_addr  = da;
      dmem_wdata = dwd;
      mem_resp   = mr;
      mem_rdata  = mrd;
   endtask

   // One clock cycle of inputs; returns at the falling edge with outputs settled.
   task automatic drive(input logic [3:0] irm, input logic [31:0] ia,
                        input logic [3:0] drm, input logic [3:0] dwm,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input logic mr, input logic [31:0] mrd);
      @(posedge clk);
      #1;
      apply(irm, ia, drm, dwm, da, dwd, mr, mrd);
      @(negedge clk);
   endtask

   task automatic idle();
      drive(4'h0, '0, 4'h0, 4'h0, '0, '0, 1'b0, '0);
   endtask

   task automatic mresp(input logic [31:0] d);
      drive(4'h0, '0, 4'h0, 4'h0, '0, '0, 1'b1, d);
   endtask

   // ---------------- stimulus ----------------
   int mem_cnt;

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      mem_cnt  = 0;
      rst_next = 1'b0;
      apply(4'h0, '0, 4'h0, 4'h0, '0, '0, 1'b0, '0);

      // Reset to idle
      idle();
      idle();
      rst_next = 1'b1;
      idle();
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      check("rst_mem_rmask", 32'(mem_rmask), 32'h0);
      check("rst_mem_wmask", 32'(mem_wmask), 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_resps", 32'({imem_resp, dmem_resp}), 32'h0);
      check("rst_rdata", imem_rdata | dmem_rdata, 32'h0);

      // Lone fetch, memory latency 3
      drive(4'hF, 32'h1eceb000, 4'h0, 4'h0, '0, '0, 1'b0, '0);
      check("t2_issue_rmask", 32'(mem_rmask), 32'hF);
      check("t2_issue_addr", mem_addr, 32'h1eceb000);
      idle();
      check("t2_wait_resp", 32'(imem_resp), 32'h0);
      idle();
      mresp(32'h00000013);
      check("t2_imem_resp", 32'(imem_resp), 32'h1);
      check("t2_imem_rdata", imem_rdata, 32'h00000013);
      check("t2_dmem_quiet", 32'(dmem_resp), 32'h0);

      // Simultaneous requests after reset: dmem first
      rst_next = 1'b0;
      idle();
      rst_next = 1'b1;
      drive(4'hF, 32'h1eceb004, 4'hF, 4'h0, 32'h1eceb100, '0, 1'b0, '0);
      check("t3_first_addr", mem_addr, 32'h1eceb100);
      check("t3_first_rmask", 32'(mem_rmask), 32'hF);
      idle();
      mresp(32'haaaa0001);
      check("t3_dmem_resp", 32'(dmem_resp), 32'h1);
      check("t3_dmem_rdata", dmem_rdata, 32'haaaa0001);
      check("t3_no_issue", 32'(mem_rmask), 32'h0);
      idle();
      check("t3_second_addr", mem_addr, 32'h1eceb004);
      check("t3_second_rmask", 32'(mem_rmask), 32'hF);
      mresp(32'hbbbb0002);
      check("t3_imem_rdata", imem_rdata, 32'hbbbb0002);
      check("t3_dmem_rdata_held", dmem_rdata, 32'haaaa0001);

      // Store pending behind a fetch, then round robin favours the store
      drive(4'hF, 32'h1eceb008, 4'h0, 4'h0, '0, '0, 1'b0, '0);
      drive(4'h0, '0, 4'h0, 4'h3, 32'h1eceb200, 32'hdeadbeef, 1'b0, '0);
      check("t4_store_waits", 32'(mem_wmask), 32'h0);
      mresp(32'h00000011);
      check("t4_imem_resp", 32'(imem_resp), 32'h1);
      drive(4'hF, 32'h1eceb00c, 4'h0, 4'h0, '0, '0, 1'b0, '0);
      check("t4_store_wmask", 32'(mem_wmask), 32'h3);
      check("t4_store_wdata", mem_wdata, 32'hdeadbeef);
      check("t4_store_addr", mem_addr, 32'h1eceb200);
      mresp(32'h00000005);
      check("t4_store_resp", 32'(dmem_resp), 32'h1);
      idle();
      check("t4_fetch_addr", mem_addr, 32'h1eceb00c);
      mresp(32'h00000077);

      // New fetch in the response cycle of the previous one
      drive(4'hF, 32'h1eceb010, 4'h0, 4'h0, '0, '0, 1'b0, '0);
      drive(4'hF, 32'h1eceb014, 4'h0, 4'h0, '0, '0, 1'b1, 32'h00000099);
      check("t5_prev_resp", 32'(imem_resp), 32'h1);
      check("t5_prev_rdata", imem_rdata, 32'h00000099);
      check("t5_no_same_cycle_issue", 32'(mem_rmask), 32'h0);
      idle();
      check("t5_next_issue", mem_addr, 32'h1eceb014);
      mresp(32'h00000055);

      // Reset while dmem is outstanding and imem is pending
      drive(4'h0, '0, 4'hF, 4'h0, 32'h1eceb300, '0, 1'b0, '0);
      drive(4'hF, 32'h1eceb018, 4'h0, 4'h0, '0, '0, 1'b0, '0);
      rst_next = 1'b0;
      idle();
      rst_next = 1'b1;
      mresp(32'h000000ff);
      check("t6_no_dmem_resp", 32'(dmem_resp), 32'h0);
      check("t6_no_imem_resp", 32'(imem_resp), 32'h0);
      check("t6_state", 32'(dbg_state), 32'(IDLE));
      idle();
      check("t6_pending_dropped", 32'(mem_rmask), 32'h0);

      // Random traffic with memory latency 1..4 and occasional stray responses
      for (int c = 0; c < 3000; c++) begin
         logic        mr;
         logic        ok_i, ok_d;
         logic [3:0]  irm, drm, dwm;
         @(posedge clk);
         #1;
         mr = 1'b0;
         if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) mr = 1'b1;
         end else if (owner == 0 && $urandom_range(0, 15) == 0) begin
            mr = 1'b1;
         end
         ok_i = (qi.size() == 0 && owner != 1) || (owner == 1 && mr);
         ok_d = (qd.size() == 0 && owner != 2) || (owner == 2 && mr);
         irm = 4'h0;
         drm = 4'h0;
         dwm = 4'h0;
         if (ok_i && $urandom_range(0, 2) == 0) irm = 4'($urandom_range(1, 15));
         if (ok_d && $urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 1) == 0) drm = 4'($urandom_range(1, 15));
            else                           dwm = 4'($urandom_range(1, 15));
         end
         apply(irm, $urandom, drm, dwm, $urandom, $urandom, mr, $urandom);
         @(negedge clk);
         if ((|mem_rmask) || (|mem_wmask)) mem_cnt = $urandom_range(1, 4);
      end

      idle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
